instr_encoder_loader: RTL

- Encoder counterpart of the single-cycle core's opcode decoder.
- Accepts symbolic instruction commands (kind plus register and immediate fields) and packs them into 32-bit RV32I words.
- Writes the words sequentially into instruction memory from word address 0.
- Used by boot/test infrastructure to load programs for the R-type/lw/sw/beq/addi subset the core executes.

---
 rtl/instr_encoder_loader_pkg.sv | 26 ++
 rtl/instr_encoder_loader_packer.sv | 35 +++
 rtl/instr_encoder_loader.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared encodings for the RV32I instruction encoder/loader: opcodes, command kinds and the
// canonical NOP word.
package instr_encoder_loader_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    KindR    = 3'd0,
    KindLw   = 3'd1,
    KindSw   = 3'd2,
    KindBeq  = 3'd3,
    KindAddi = 3'd4
  } cmd_kind_e;

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational field packer: turns a symbolic command into an RV32I word and flags commands
// that cannot be encoded.
module instr_field_packer
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic        alt_i,
  input  logic [12:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (kind_i)
      KindR:    word_o = {(alt_i ? F7_ALT : 7'b0), rs2_i, rs1_i, funct3_i, rd_i, OP_R};
      KindLw:   word_o = {imm_i[11:0], rs1_i, F3_WORD, rd_i, OP_LOAD};
      KindSw:   word_o = {imm_i[11:5], rs2_i, rs1_i, F3_WORD, imm_i[4:0], OP_STORE};
      KindBeq: begin
        word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ, imm_i[4:1], imm_i[11],
                     OP_BRANCH};
        // Branch targets are halfword aligned; bit 0 has no place in the encoding.
        illegal_o = imm_i[0];
      end
      KindAddi: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_IMM};
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Loads encoded RV32I words into instruction memory from address 0 upward.
// Optional NOP padding to the end of memory is built when ENC_NOP_PAD_EN is defined.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_kind_i,
  input  logic [4:0]        cmd_rd_i,
  input  logic [4:0]        cmd_rs1_i,
  input  logic [4:0]        cmd_rs2_i,
  input  logic [2:0]        cmd_funct3_i,
  input  logic              cmd_alt_i,
  input  logic [12:0]       cmd_imm_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  input  logic              imem_ready_i,
  output logic              full_o,
  output logic              err_o,
  output logic [ADDR_W:0]   count_o,
  input  logic              pad_i
);

`ifdef ENC_NOP_PAD_EN
  typedef enum logic [1:0] {StIdle, StWrite, StFull, StPad} state_e;
`else
  typedef enum logic [1:0] {StIdle, StWrite, StFull} state_e;
`endif

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;

  logic [31:0]         pk_word;
  logic                pk_illegal;
  logic                full;
  logic                pad_go;
  logic                accept;
  logic [ADDR_W:0]     count_inc;

  instr_field_packer u_packer (
    .kind_i    (cmd_kind_i),
    .rd_i      (cmd_rd_i),
    .rs1_i     (cmd_rs1_i),
    .rs2_i     (cmd_rs2_i),
    .funct3_i  (cmd_funct3_i),
    .alt_i     (cmd_alt_i),
    .imm_i     (cmd_imm_i),
    .word_o    (pk_word),
    .illegal_o (pk_illegal)
  );

  assign full      = (count_q == DepthW);
  assign count_inc = count_q + 1'b1;

`ifdef ENC_NOP_PAD_EN
  assign pad_go = pad_i && (state_q == StIdle) && !full && !clear_i;
`else
  logic unused_pad;
  assign unused_pad = pad_i;
  assign pad_go     = 1'b0;
`endif

  assign cmd_ready_o = (state_q == StIdle) && !full && !clear_i && !pad_go;
  assign accept      = cmd_valid_i && cmd_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    if (clear_i) begin
      state_d = StIdle;
      addr_d  = '0;
      count_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pad_go) begin
`ifdef ENC_NOP_PAD_EN
            state_d = StPad;
`endif
            wdata_d = NOP_WORD;
          end else if (accept) begin
            if (pk_illegal) begin
              err_d = 1'b1;
            end else begin
              wdata_d = pk_word;
              state_d = StWrite;
            end
          end
        end
        StWrite: begin
          if (imem_ready_i) begin
            addr_d  = addr_q + 1'b1;
            count_d = count_inc;
            state_d = (count_inc == DepthW) ? StFull : StIdle;
          end
        end
`ifdef ENC_NOP_PAD_EN
        StPad: begin
          if (imem_ready_i) begin
            addr_d  = addr_q + 1'b1;
            count_d = count_inc;
            state_d = (count_inc == DepthW) ? StFull : StPad;
          end
        end
`endif
        StFull:  ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    imem_we_o = (state_q == StWrite);
`ifdef ENC_NOP_PAD_EN
    imem_we_o = imem_we_o || (state_q == StPad);
`endif
  end

  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign full_o       = full;
  assign err_o        = err_q;
  assign count_o      = count_q;

endmodule
